// File: rtl/instr_packer.sv
// RV32I instruction encoder: scatters decoded fields into R/I/S/B/U/J words and streams them
// into instruction memory. Define INSTR_PACKER_RANGECHK_EN to enable immediate/format checks.
module instr_packer #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        fmt,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [31:0]       imm,
    input  logic              flush,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              err
);

    typedef enum logic {StRun, StFull} state_e;

    localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);
    // Last slot before wrap; reaching it fills the memory.
    localparam logic [ADDR_W-1:0] LastAddr = BaseAddr + {ADDR_W{1'b1}};

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] next_q, next_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              err_q, err_d;
    logic [31:0]       enc;
    logic              legal;
    logic              accept;

    always_comb begin
        enc = 32'h0000_0013;
        case (fmt)
            3'd0:    enc = {funct7, rs2, rs1, funct3, rd, opcode};
            3'd1:    enc = {imm[11:0], rs1, funct3, rd, opcode};
            3'd2:    enc = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            3'd3:    enc = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            3'd4:    enc = {imm[31:12], rd, opcode};
            3'd5:    enc = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            default: enc = 32'h0000_0013;
        endcase
    end

`ifdef INSTR_PACKER_RANGECHK_EN
    // Sign-extension checks: the dropped high bits must all copy the top kept bit.
    always_comb begin
        legal = 1'b0;
        case (fmt)
            3'd0:    legal = 1'b1;
            3'd1,
            3'd2:    legal = (&imm[31:11]) | ~(|imm[31:11]);
            3'd3:    legal = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
            3'd4:    legal = ~(|imm[11:0]);
            3'd5:    legal = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];
            default: legal = 1'b0;
        endcase
    end
    assign err = err_q;
`else
    logic unused_imm0;
    assign unused_imm0 = imm[0];
    assign legal       = 1'b1;
    assign err         = 1'b0;
`endif

    assign in_ready = (state_q == StRun) & ~flush;
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d = state_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        next_d  = next_q;
        wdata_d = wdata_q;
        count_d = count_q;
        err_d   = err_q;
        if (flush) begin
            state_d = StRun;
            next_d  = BaseAddr;
            count_d = '0;
            err_d   = 1'b0;
        end else if (accept) begin
            if (legal) begin
                we_d    = 1'b1;
                addr_d  = next_q;
                wdata_d = enc;
                next_d  = next_q + ADDR_W'(1);
                count_d = count_q + (ADDR_W + 1)'(1);
                if (next_q == LastAddr) begin
                    state_d = StFull;
                end
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StRun;
            we_q    <= 1'b0;
            addr_q  <= BaseAddr;
            next_q  <= BaseAddr;
            wdata_q <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            next_q  <= next_d;
            wdata_q <= wdata_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign count      = count_q;

endmodule
